// File: rtl/gray_pkg.sv
// Shared types and helpers for the pipelined Gray/binary converter.
// Per-stage control record, conversion mode encoding, chunk slicing and popcount.
package gray_pkg;

  typedef enum logic {
    MODE_G2B = 1'b0,
    MODE_B2G = 1'b1
  } conv_mode_e;

  // Widest word the step checker's popcount handles.
  localparam int GRAY_MAX_W = 64;

  // Control half of a pipeline stage; the partial binary and raw input words travel beside it.
  typedef struct packed {
    logic       valid;
    conv_mode_e mode;
    logic       err;
    logic       carry;
  } stage_ctl_t;

  // Bit range a stage resolves; hi < lo means the stage only registers.
  typedef struct packed {
    int hi;
    int lo;
  } chunk_t;

  function automatic int popcount(logic [GRAY_MAX_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      n = n + (v[i] ? 1 : 0);
    end
    return n;
  endfunction

  function automatic chunk_t chunk_bounds(int width, int chunk, int s);
    chunk_t cb;
    cb.hi = width - 1 - s * chunk;
    cb.lo = width - (s + 1) * chunk;
    if (cb.lo < 0) cb.lo = 0;
    return cb;
  endfunction

endpackage

// File: rtl/gray_conv_stage.sv
// One registered stage of the converter: resolves its MSB-first slice of the
// Gray-to-binary prefix XOR (or forms binary-to-Gray in stage 0) and holds the result.
module gray_conv_stage
  import gray_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             down_adv,
  output logic             adv,
  input  stage_ctl_t       d_ctl,
  input  logic [WIDTH-1:0] d_bin,
  input  logic [WIDTH-1:0] d_raw,
  output stage_ctl_t       q_ctl,
  output logic [WIDTH-1:0] q_bin,
  output logic [WIDTH-1:0] q_raw
);

  localparam chunk_t CB = chunk_bounds(WIDTH, CHUNK, IDX);
  localparam int     HI = CB.hi;
  localparam int     LO = CB.lo;

  stage_ctl_t       ctl_nxt;
  logic [WIDTH-1:0] bin_nxt;
  logic             c;

  always_comb begin
    ctl_nxt = d_ctl;
    bin_nxt = d_bin;
    c       = d_ctl.carry;
    if (d_ctl.mode == MODE_B2G) begin
      if (IDX == 0) bin_nxt = d_raw ^ (d_raw >> 1);
    end else begin
      // Carry enters as the lowest bit resolved by the previous stage.
      for (int k = WIDTH - 1; k >= 0; k--) begin
        if (k <= HI && k >= LO) begin
          c          = (k == WIDTH - 1) ? d_raw[k] : (c ^ d_raw[k]);
          bin_nxt[k] = c;
        end
      end
      ctl_nxt.carry = c;
    end
  end

  assign adv = !q_ctl.valid || down_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_ctl <= '0;
      q_bin <= '0;
      q_raw <= '0;
    end else if (adv) begin
      q_ctl <= ctl_nxt;
      q_bin <= bin_nxt;
      q_raw <= d_raw;
    end
  end

endmodule

// File: rtl/gray_code_converter.sv
// Pipelined bidirectional Gray/binary converter with valid/ready on both sides
// and a single-bit-step monitor on the Gray-to-binary input stream.
module gray_code_converter
  import gray_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data,
  output logic             out_step_err
);

  localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;
  localparam int L     = STAGES - 1;

  if (WIDTH < 2 || WIDTH > GRAY_MAX_W || STAGES < 1 || STAGES > WIDTH) begin : g_bad_params
    $error("gray_code_converter: illegal WIDTH/STAGES combination");
  end

  logic             xfer;
  logic             g2b_in;
  logic             step_err;
  logic [WIDTH-1:0] hist_q;
  logic             hist_vld_q;

  assign xfer     = in_valid && in_ready;
  assign g2b_in   = (in_mode == MODE_G2B);
  assign step_err = g2b_in && hist_vld_q &&
                    (popcount(GRAY_MAX_W'(in_data ^ hist_q)) != 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_vld_q <= 1'b0;
    end else if (xfer && g2b_in) begin
      hist_vld_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && xfer && g2b_in) hist_q <= in_data;
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    stage_ctl_t       d_ctl;
    stage_ctl_t       q_ctl;
    logic [WIDTH-1:0] d_bin;
    logic [WIDTH-1:0] d_raw;
    logic [WIDTH-1:0] q_bin;
    logic [WIDTH-1:0] q_raw;
    logic             adv;
    logic             down_adv;

    if (i == 0) begin : g_head
      assign d_ctl = '{valid: in_valid, mode: conv_mode_e'(in_mode), err: step_err, carry: 1'b0};
      assign d_bin = '0;
      assign d_raw = in_data;
    end else begin : g_body
      assign d_ctl = g_stage[i-1].q_ctl;
      assign d_bin = g_stage[i-1].q_bin;
      assign d_raw = g_stage[i-1].q_raw;
    end

    // Stall propagates combinationally from out_ready back to in_ready.
    if (i == STAGES - 1) begin : g_tail
      assign down_adv = out_ready;
    end else begin : g_link
      assign down_adv = g_stage[i+1].adv;
    end

    gray_conv_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (i)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .down_adv (down_adv),
      .adv      (adv),
      .d_ctl    (d_ctl),
      .d_bin    (d_bin),
      .d_raw    (d_raw),
      .q_ctl    (q_ctl),
      .q_bin    (q_bin),
      .q_raw    (q_raw)
    );
  end

  assign in_ready     = g_stage[0].adv;
  assign out_valid    = g_stage[L].q_ctl.valid;
  assign out_mode     = g_stage[L].q_ctl.mode;
  assign out_step_err = g_stage[L].q_ctl.err;
  assign out_data     = g_stage[L].q_bin;

  logic unused_tail;
  assign unused_tail = ^{g_stage[L].q_raw, g_stage[L].q_ctl.carry};

endmodule
